// File: rtl/cic_interpolator_variable_ahb_if.sv
`default_nettype none
// ============================================================================
// Module      : cic_interpolator_variable_ahb_if
// Description : Stream input, stream output and AHB-Lite register-bus signals
//               of the variable-rate CIC interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
interface cic_interpolator_variable_ahb_if;
  logic [31:0] tdata_s_in;
  logic        tvalid_s_in;
  logic        tready_s_in;
  logic [31:0] tdata_m_out;
  logic        tvalid_m_out;
  logic        tready_m_out;
  logic [31:0] haddr_i;
  logic [2:0]  hburst_i;
  logic [3:0]  hprot_i;
  logic [2:0]  hsize_i;
  logic [1:0]  htrans_i;
  logic [31:0] hwdata_i;
  logic        hwrite_i;
  logic        hsel_i;
  logic [31:0] hrdata_o;
  logic        hreadyout_o;
  logic        hresp_o;

  // Design side
  modport slave (
    input  tdata_s_in, tvalid_s_in, output tready_s_in,
    output tdata_m_out, tvalid_m_out, input tready_m_out,
    input  haddr_i, hburst_i, hprot_i, hsize_i, htrans_i, hwdata_i, hwrite_i, hsel_i,
    output hrdata_o, hreadyout_o, hresp_o
  );

  // Environment side
  modport master (
    output tdata_s_in, tvalid_s_in, input tready_s_in,
    input  tdata_m_out, tvalid_m_out, output tready_m_out,
    output haddr_i, hburst_i, hprot_i, hsize_i, htrans_i, hwdata_i, hwrite_i, hsel_i,
    input  hrdata_o, hreadyout_o, hresp_o
  );
endinterface
`default_nettype wire

// File: rtl/cic_interpolator_variable_ahb.sv
`default_nettype none
// ============================================================================
// Module      : cic_interpolator_variable_ahb
// Description : Variable-rate CIC interpolator. Each accepted input runs the
//               comb cascade once, then the integrator cascade is stepped
//               R times (input on the first step, zeros after), producing R
//               shifted/truncated outputs. Rate, shift and enable live in an
//               AHB-Lite register window.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_interpolator_variable_ahb #(
  parameter int          INPUT_DW    = 16,
  parameter int          OUTPUT_DW   = 16,
  parameter int          N_STAGES    = 3,
  parameter int          R_MAX       = 64,
  parameter logic [31:0] BUS_ADDR    = 32'h0000_0000,
  parameter int          BUS_PERI_AW = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  cic_interpolator_variable_ahb_if.slave bus
);

  localparam int c_W  = INPUT_DW + N_STAGES * $clog2(R_MAX);
  localparam int c_SW = $clog2(c_W);
  localparam int c_RW = $clog2(R_MAX + 1);

  localparam logic [BUS_PERI_AW-1:0] c_OFF_CTRL   = BUS_PERI_AW'(8'h00);
  localparam logic [BUS_PERI_AW-1:0] c_OFF_RATE   = BUS_PERI_AW'(8'h04);
  localparam logic [BUS_PERI_AW-1:0] c_OFF_SHIFT  = BUS_PERI_AW'(8'h08);
  localparam logic [BUS_PERI_AW-1:0] c_OFF_STATUS = BUS_PERI_AW'(8'h0C);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_en, r_clr;
  logic [c_RW-1:0]          r_rate, r_rate_s, r_phase;
  logic [c_SW-1:0]          r_shift, r_shift_s;
  logic                     r_wr_pend, r_rd_pend;
  logic [BUS_PERI_AW-1:0]   r_addr;
  logic                     w_sel, w_accept, w_step, w_last;
  logic signed [c_W-1:0]    r_cd  [N_STAGES];
  logic signed [c_W-1:0]    r_int [N_STAGES];
  logic signed [c_W-1:0]    w_c   [N_STAGES+1];
  logic signed [c_W-1:0]    w_i   [N_STAGES];
  logic signed [c_W-1:0]    r_u, w_u_in, w_shifted;
  logic [31:0]              r_tdata, w_rdata;
  logic                     r_tvalid;
  logic                     w_unused;

  assign w_sel = bus.hsel_i & bus.htrans_i[1] &
                 (bus.haddr_i[31:BUS_PERI_AW] == BUS_ADDR[31:BUS_PERI_AW]);

  // AHB address-phase capture and data-phase register writes; CLR is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_addr    <= '0;
      r_en      <= 1'b0;
      r_clr     <= 1'b0;
      r_rate    <= c_RW'(1);
      r_shift   <= '0;
    end else if (ce) begin
      r_wr_pend <= w_sel & bus.hwrite_i;
      r_rd_pend <= w_sel & ~bus.hwrite_i;
      r_addr    <= bus.haddr_i[BUS_PERI_AW-1:0];
      r_clr     <= 1'b0;
      if (r_wr_pend) begin
        case (r_addr)
          c_OFF_CTRL: begin
            r_en  <= bus.hwdata_i[0];
            r_clr <= bus.hwdata_i[1];
          end
          c_OFF_RATE: begin
            if (bus.hwdata_i == 32'd0)
              r_rate <= c_RW'(1);
            else if (bus.hwdata_i > 32'(R_MAX))
              r_rate <= c_RW'(R_MAX);
            else
              r_rate <= bus.hwdata_i[c_RW-1:0];
          end
          c_OFF_SHIFT: r_shift <= bus.hwdata_i[c_SW-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read data is driven only while a read data phase is in progress
  always_comb begin
    w_rdata = 32'd0;
    if (r_rd_pend) begin
      case (r_addr)
        c_OFF_CTRL:   w_rdata = {31'd0, r_en};
        c_OFF_RATE:   w_rdata = 32'(r_rate);
        c_OFF_SHIFT:  w_rdata = 32'(r_shift);
        c_OFF_STATUS: w_rdata = {31'd0, r_state == ST_RUN};
        default:      w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.hrdata_o    = w_rdata;
  assign bus.hreadyout_o = 1'b1;
  assign bus.hresp_o     = 1'b0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else if (ce)
      r_state <= w_state_nxt;
  end

  // FSM next state: accept one input in IDLE, step R times in RUN; a pending CLR wins
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = (r_phase == (r_rate_s - c_RW'(1)));
    if (r_clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.tvalid_s_in & r_en) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_step = ~r_tvalid | bus.tready_m_out;
          if (w_step & w_last)
            w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ce gates ready so an upstream beat is never taken while state is frozen
  assign bus.tready_s_in = (r_state == ST_IDLE) & r_en & ~r_clr & ce;

  assign w_c[0] = {{(c_W-INPUT_DW){bus.tdata_s_in[INPUT_DW-1]}}, bus.tdata_s_in[INPUT_DW-1:0]};
  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    assign w_c[k+1] = w_c[k] - r_cd[k];
  end

  // Zero-stuffing: only the first step of a burst carries the comb output
  assign w_u_in = (r_phase == '0) ? r_u : '0;
  assign w_i[0] = r_int[0] + w_u_in;
  for (genvar k = 1; k < N_STAGES; k++) begin : g_integ
    assign w_i[k] = w_i[k-1] + r_int[k];
  end

  assign w_shifted = w_i[N_STAGES-1] >>> r_shift_s;

  // Datapath: comb update on accept, integrator/output update on each step
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_cd[k]  <= '0;
        r_int[k] <= '0;
      end
      r_u       <= '0;
      r_phase   <= '0;
      r_rate_s  <= c_RW'(1);
      r_shift_s <= '0;
      r_tdata   <= 32'd0;
      r_tvalid  <= 1'b0;
    end else if (ce) begin
      if (r_clr) begin
        for (int k = 0; k < N_STAGES; k++) begin
          r_cd[k]  <= '0;
          r_int[k] <= '0;
        end
        r_u      <= '0;
        r_phase  <= '0;
        r_tvalid <= 1'b0;
      end else begin
        if (w_accept) begin
          for (int k = 0; k < N_STAGES; k++)
            r_cd[k] <= w_c[k];
          r_u       <= w_c[N_STAGES];
          r_rate_s  <= r_rate;
          r_shift_s <= r_shift;
          r_phase   <= '0;
        end
        if (w_step) begin
          for (int k = 0; k < N_STAGES; k++)
            r_int[k] <= w_i[k];
          r_tdata  <= {{(32-OUTPUT_DW){w_shifted[OUTPUT_DW-1]}}, w_shifted[OUTPUT_DW-1:0]};
          r_tvalid <= 1'b1;
          r_phase  <= r_phase + c_RW'(1);
        end else if (bus.tready_m_out) begin
          r_tvalid <= 1'b0;
        end
      end
    end
  end

  assign bus.tdata_m_out  = r_tdata;
  assign bus.tvalid_m_out = r_tvalid;

  assign w_unused = ^{bus.hburst_i, bus.hprot_i, bus.hsize_i, bus.htrans_i[0],
                      bus.tdata_s_in[31:INPUT_DW], w_shifted[c_W-1:OUTPUT_DW]};

endmodule
`default_nettype wire

// File: doc/cic_interpolator_variable_ahb.md
Name: cic_interpolator_variable_ahb

Overview:
- Variable-rate CIC interpolator, the transmit-side counterpart of the variable-rate CIC decimator.
- Takes low-rate signed samples on an AXI-Stream slave and emits R upsampled, CIC-filtered samples per input on an AXI-Stream master.
- Rate, output shift and enable are set through an AHB-Lite slave register window. It sits in the DSP chain ahead of the DAC path.

Parameters:
INPUT_DW, 16, signed input sample width (tdata_s_in[INPUT_DW-1:0])
OUTPUT_DW, 16, signed output sample width, sign-extended to 32 on tdata_m_out
N_STAGES, 3, number of comb and integrator stages (differential delay fixed at 1)
R_MAX, 64, maximum interpolation ratio
BUS_ADDR, 32'h0000_0000, peripheral base address
BUS_PERI_AW, 8, peripheral address window width; haddr[31:BUS_PERI_AW] must equal BUS_ADDR[31:BUS_PERI_AW]

Ports:
clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; when 0, all state holds (AHB register writes included)
tdata_s_in  in  32  input sample, low INPUT_DW bits, signed
tvalid_s_in  in  1  input valid
tready_s_in  out  1  input ready
tdata_m_out  out  32  output sample, sign-extended OUTPUT_DW
tvalid_m_out  out  1  output valid
tready_m_out  in  1  downstream ready
haddr_i  in  32  AHB address
hburst_i  in  3  ignored
hprot_i  in  4  ignored
hsize_i  in  3  ignored; all accesses treated as 32-bit
htrans_i  in  2  AHB transfer type; the transfer is active when bit 1 is set
hwdata_i  in  32  write data (data phase)
hwrite_i  in  1  write strobe
hsel_i  in  1  slave select
hrdata_o  out  32  read data (data phase)
hreadyout_o  out  1  always 1 (zero wait states)
hresp_o  out  1  always 0 (OKAY)

Behaviour:
- Reset values: tready_s_in=0, tvalid_m_out=0, tdata_m_out=0, hrdata_o=0, hreadyout_o=1, hresp_o=0, CTRL=0, RATE=1, SHIFT=0. All comb delays, integrators and the phase counter are cleared to 0. The FSM starts in IDLE.
- Internal width W = INPUT_DW + N_STAGES*clog2(R_MAX).
  - Input is sign-extended to W.
  - All comb and integrator arithmetic is two's-complement modulo 2^W. Wrap-around is intended.
- Registers (offset = haddr[BUS_PERI_AW-1:0]):
  - 0x00 CTRL: bit0 EN; bit1 CLR, write-1 self-clearing, reads 0.
  - 0x04 RATE: write 0 stores 1; write >R_MAX stores R_MAX.
  - 0x08 SHIFT: width clog2(W).
  - 0x0C STATUS: read-only; bit0 BUSY (FSM in RUN).
  - Unmapped offsets read 0; writes to them are ignored.
- AHB timing:
  - Address phase captured when hsel_i & htrans_i[1] & address match.
  - Write takes effect at the end of the data phase.
  - hrdata_o is valid during the data phase. It is 0 when no read is in progress.
- FSM, IDLE:
  - tready_s_in = EN & ~CLR-pending.
  - On handshake, the comb cascade updates from the input. Stage k outputs c_k = c_{k-1} - c_{k-1}_d, and every delay register updates.
  - The final comb value is held as U.
  - RATE and SHIFT are latched into shadow registers (R_s, S_s). Phase is set to 0 and the FSM goes to RUN.
- FSM, RUN:
  - tready_s_in=0.
  - A step occurs when (~tvalid_m_out | tready_m_out). Each step does the following:
    - u = (phase==0) ? U : 0.
    - The integrator cascade updates in the same cycle: I1+=u; Ik+=Ik-1(new).
    - The output register loads (I_N(new) >>> S_s)[OUTPUT_DW-1:0], sign-extended to 32. This is truncation with no saturation.
    - tvalid_m_out is set to 1 and phase increments.
  - After the step with phase==R_s-1, the FSM returns to IDLE.
- Latency: the first output is valid 2 cycles after input acceptance. With tready_m_out held at 1, throughput is 1 output per cycle and R_s+1 cycles per input.
- AXI-S output rules:
  - tvalid_m_out stays 1 and tdata_m_out stays stable until accepted.
  - If it is accepted and no step occurs in the same cycle, tvalid_m_out drops to 0.
- RATE/SHIFT written mid-burst: the current burst completes with the shadow values; the new values apply from the next input.
- EN cleared mid-burst: the current burst completes, then no new input is accepted.
- CLR: the next cycle clears combs, integrators, U, phase and tvalid_m_out, and the FSM goes to IDLE. Any pending output is discarded.
- Reset has priority over everything. Reset mid-burst returns all state to the reset values.

Test Plan:
1. Assert reset 3 cycles, ce=1 -> every output at its reset value; reading 0x04 returns 1 and 0x00 returns 0.
2. Write RATE=0, read back -> 1. Write RATE=100, read back -> 64. Write SHIFT=5, read back -> 5. Read 0x10 -> 0. hreadyout_o=1 and hresp_o=0 throughout.
3. Impulse test:
   - Setup: EN=1, RATE=4, SHIFT=0, N_STAGES=3, tready_m_out=1.
   - Stimulus: input 1, then zeros.
   - Required outputs: 1,3,6,10,12,12,10,6,3,1,0,0,... with 4 outputs per accepted input.
4. DC test: RATE=4, SHIFT=4, constant input 100 -> steady-state outputs all 100 (gain R^(N-1)=16). Input -100 -> -100.
5. Backpressure test:
   - Stimulus: tready_m_out=0 for 5 cycles mid-burst.
   - Required: tvalid_m_out stays 1 and tdata_m_out is unchanged; tready_s_in=0.
   - After release, the full sequence arrives with no loss or duplication.
6. Mid-burst changes:
   - Write RATE=2 during an R=4 burst -> the burst emits 4 samples; the next input emits 2.
   - Write CLR mid-burst -> tvalid_m_out drops the next cycle, STATUS.BUSY=0, and the next impulse reproduces scenario 3's sequence for R=2.
